// File: rtl/vxe_vpu_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vxe_vpu_rsp_pkg
// Purpose  : Shared types, client ids and status/txnid field layout for the VPU
//            response collector.
// Revision : 1.0  initial release
// ============================================================================
package vxe_vpu_rsp_pkg;

    localparam logic [1:0] CLNT_HOST = 2'b00;
    localparam logic [1:0] CLNT_VPU0 = 2'b01;
    localparam logic [1:0] CLNT_VPU1 = 2'b10;
    localparam logic [1:0] CLNT_DMA  = 2'b11;

    localparam logic ARG_RS = 1'b0;
    localparam logic ARG_RT = 1'b1;

    localparam int RSS_W   = 9;
    localparam int TXNID_W = 6;
    localparam int ERR_W   = 2;
    localparam int RSD_W   = 64;
    localparam int NTHR    = 8;
    localparam int THR_W   = 3;

    // Status word layout, MSB first: txnid[8:3], rnw[2], err[1:0]
    typedef struct packed {
        logic [TXNID_W-1:0] txnid;
        logic               rnw;
        logic [ERR_W-1:0]   err;
    } txnress_t;

    // Transaction id layout, MSB first: client[5:4], thread[3:1], arg[0]
    typedef struct packed {
        logic [1:0]       client;
        logic [THR_W-1:0] thread;
        logic             arg;
    } txnid_t;

    function automatic txnress_t vxe_txnress_decoder(input logic [RSS_W-1:0] rss);
        return txnress_t'(rss);
    endfunction

    function automatic txnid_t vxe_txnid_decoder(input logic [TXNID_W-1:0] txnid);
        return txnid_t'(txnid);
    endfunction

    function automatic logic [RSS_W-1:0] rss_pack(
        input logic [1:0]       client,
        input logic [THR_W-1:0] thread,
        input logic             arg,
        input logic             rnw,
        input logic [ERR_W-1:0] err
    );
        return {client, thread, arg, rnw, err};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vxe_vpu_rsp_collect_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vxe_vpu_rsp_fifo
// Purpose  : Parameterised synchronous FIFO; pointers carry a wrap bit so that
//            full and empty come straight from registered state.
// Revision : 1.0  initial release
// ============================================================================
module vxe_vpu_rsp_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                     (wr_ptr_q[DEPTH_LOG2]     != rd_ptr_q[DEPTH_LOG2]);

    // Guard both sides so a misbehaving caller cannot corrupt the pointers
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    assign data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vxe_vpu_rsp_collect.sv
`default_nettype none
// ============================================================================
// Module   : vxe_vpu_rsp_collect
// Purpose  : Per-VPU response collector; pairs read status with data, steers
//            operands into per-thread Rs/Rt slots, pulses write completion.
// Revision : 1.0  initial release
// ============================================================================
module vxe_vpu_rsp_collect
    import vxe_vpu_rsp_pkg::*;
#(
    parameter logic [1:0] CLIENT_ID       = CLNT_VPU0,
    parameter int         FIFO_DEPTH_LOG2 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rss_wr,
    input  logic [RSS_W-1:0]      i_rss,
    output logic                  o_rss_rdy,
    input  logic                  i_rsd_wr,
    input  logic [RSD_W-1:0]      i_rsd,
    output logic                  o_rsd_rdy,
    output logic [NTHR-1:0]       o_rs_vld,
    output logic [NTHR-1:0]       o_rt_vld,
    output logic [NTHR*RSD_W-1:0] o_rs_data,
    output logic [NTHR*RSD_W-1:0] o_rt_data,
    input  logic [NTHR-1:0]       i_consume,
    output logic [NTHR-1:0]       o_wr_done,
    output logic [NTHR-1:0]       o_err_vld,
    input  logic [NTHR-1:0]       i_err_clr,
    output logic                  o_misroute
);

    localparam logic [0:0] PAIR_IDLE  = 1'b0;
    localparam logic [0:0] PAIR_WAITD = 1'b1;

    logic             rss_push, rss_pop, rss_full, rss_empty;
    logic             rsd_push, rsd_pop, rsd_full, rsd_empty;
    logic [RSS_W-1:0] rss_head;
    logic [RSD_W-1:0] rsd_head;

    txnress_t         head;
    txnid_t           id;
    logic             id_match;
    logic             slot_busy;
    logic             slot_free;
    logic             fill;
    logic             misroute_set;
    logic [NTHR-1:0]  err_set;

    logic [0:0]       state_q, state_d;
    logic [NTHR-1:0]  rs_vld_q, rs_vld_d;
    logic [NTHR-1:0]  rt_vld_q, rt_vld_d;
    logic [NTHR-1:0]  wr_done_q, wr_done_d;
    logic [NTHR-1:0]  err_vld_q, err_vld_d;
    logic             misroute_q, misroute_d;
    logic [RSD_W-1:0] rs_data_q [NTHR];
    logic [RSD_W-1:0] rt_data_q [NTHR];

    // Ready depends only on registered pointers, never on the incoming wr
    assign o_rss_rdy = !rss_full;
    assign o_rsd_rdy = !rsd_full;
    assign rss_push  = i_rss_wr && !rss_full;
    assign rsd_push  = i_rsd_wr && !rsd_full;

    vxe_vpu_rsp_fifo #(
        .WIDTH      (RSS_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_rss_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rss_push),
        .data_i  (i_rss),
        .pop_i   (rss_pop),
        .data_o  (rss_head),
        .full_o  (rss_full),
        .empty_o (rss_empty)
    );

    vxe_vpu_rsp_fifo #(
        .WIDTH      (RSD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_rsd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsd_push),
        .data_i  (i_rsd),
        .pop_i   (rsd_pop),
        .data_o  (rsd_head),
        .full_o  (rsd_full),
        .empty_o (rsd_empty)
    );

    assign head     = vxe_txnress_decoder(rss_head);
    assign id       = vxe_txnid_decoder(head.txnid);
    assign id_match = (id.client == CLIENT_ID);

    // A slot drained by the consumer this cycle may be refilled at the same edge
    assign slot_busy = (id.arg == ARG_RT) ? rt_vld_q[id.thread] : rs_vld_q[id.thread];
    assign slot_free = !slot_busy || i_consume[id.thread];

    always_comb begin
        rss_pop      = 1'b0;
        rsd_pop      = 1'b0;
        fill         = 1'b0;
        misroute_set = 1'b0;
        wr_done_d    = '0;
        err_set      = '0;
        if (!rss_empty) begin
            if (!head.rnw) begin
                rss_pop = 1'b1;
                if (id_match) begin
                    wr_done_d[id.thread] = 1'b1;
                end else begin
                    misroute_set = 1'b1;
                end
            end else if (!rsd_empty) begin
                if (!id_match) begin
                    rss_pop      = 1'b1;
                    rsd_pop      = 1'b1;
                    misroute_set = 1'b1;
                end else if (slot_free) begin
                    rss_pop = 1'b1;
                    rsd_pop = 1'b1;
                    fill    = 1'b1;
                end
            end
            if (rss_pop && (head.err != '0)) begin
                err_set[id.thread] = 1'b1;
            end
        end
    end

    always_comb begin
        rs_vld_d = rs_vld_q & ~i_consume;
        rt_vld_d = rt_vld_q & ~i_consume;
        if (fill) begin
            if (id.arg == ARG_RT) begin
                rt_vld_d[id.thread] = 1'b1;
            end else begin
                rs_vld_d[id.thread] = 1'b1;
            end
        end
        err_vld_d  = (err_vld_q & ~i_err_clr) | err_set;
        misroute_d = misroute_q | misroute_set;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAIR_IDLE: begin
                if (!rss_empty && head.rnw && rsd_empty) begin
                    state_d = PAIR_WAITD;
                end
            end
            PAIR_WAITD: begin
                if (rsd_pop) begin
                    state_d = PAIR_IDLE;
                end
            end
            default: state_d = PAIR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PAIR_IDLE;
            rs_vld_q   <= '0;
            rt_vld_q   <= '0;
            wr_done_q  <= '0;
            err_vld_q  <= '0;
            misroute_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_vld_q   <= rs_vld_d;
            rt_vld_q   <= rt_vld_d;
            wr_done_q  <= wr_done_d;
            err_vld_q  <= err_vld_d;
            misroute_q <= misroute_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            if (id.arg == ARG_RT) begin
                rt_data_q[id.thread] <= rsd_head;
            end else begin
                rs_data_q[id.thread] <= rsd_head;
            end
        end
    end

    generate
        for (genvar g = 0; g < NTHR; g++) begin : g_pack
            assign o_rs_data[RSD_W*g +: RSD_W] = rs_data_q[g];
            assign o_rt_data[RSD_W*g +: RSD_W] = rt_data_q[g];
        end
    endgenerate

    assign o_rs_vld   = rs_vld_q;
    assign o_rt_vld   = rt_vld_q;
    assign o_wr_done  = wr_done_q;
    assign o_err_vld  = err_vld_q;
    assign o_misroute = misroute_q;

endmodule
`default_nettype wire

// File: tb/tb_vxe_vpu_rsp_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_vxe_vpu_rsp_collect
// Purpose  : Self-checking bench: vector table plus hand sequences, with a
//            scoreboard of expected slot fills and write completions.
// Revision : 1.0  initial release
// ============================================================================
module tb_vxe_vpu_rsp_collect;
    import vxe_vpu_rsp_pkg::*;

    logic           clk;
    logic           rst;
    logic           i_rss_wr;
    logic [8:0]     i_rss;
    logic           o_rss_rdy;
    logic           i_rsd_wr;
    logic [63:0]    i_rsd;
    logic           o_rsd_rdy;
    logic [7:0]     o_rs_vld;
    logic [7:0]     o_rt_vld;
    logic [511:0]   o_rs_data;
    logic [511:0]   o_rt_data;
    logic [7:0]     i_consume;
    logic [7:0]     o_wr_done;
    logic [7:0]     o_err_vld;
    logic [7:0]     i_err_clr;
    logic           o_misroute;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        is_wr;
        logic [2:0]  thr;
        logic        arg;
        logic [63:0] data;
    } ev_t;
    ev_t sb_q[$];

    typedef struct {
        logic [2:0]  thr;
        logic        arg;
        logic        rnw;
        logic [1:0]  err;
        logic [63:0] data;
        logic [7:0]  e_rs;
        logic [7:0]  e_rt;
        logic [7:0]  e_wd;
        logic [7:0]  e_err;
    } vec_t;
    vec_t vecs[6];

    vxe_vpu_rsp_collect #(
        .CLIENT_ID       (CLNT_VPU0),
        .FIFO_DEPTH_LOG2 (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rss_wr   (i_rss_wr),
        .i_rss      (i_rss),
        .o_rss_rdy  (o_rss_rdy),
        .i_rsd_wr   (i_rsd_wr),
        .i_rsd      (i_rsd),
        .o_rsd_rdy  (o_rsd_rdy),
        .o_rs_vld   (o_rs_vld),
        .o_rt_vld   (o_rt_vld),
        .o_rs_data  (o_rs_data),
        .o_rt_data  (o_rt_data),
        .i_consume  (i_consume),
        .o_wr_done  (o_wr_done),
        .o_err_vld  (o_err_vld),
        .i_err_clr  (i_err_clr),
        .o_misroute (o_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_read(input int t, input logic arg, input logic [63:0] d);
        ev_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_fill: thread %0d arg %0d data %0h, expected nothing", t, arg, d);
        end else begin
            e = sb_q.pop_front();
            if (e.is_wr || e.thr != 3'(t) || e.arg != arg || e.data !== d) begin
                n_err++;
                $display("FAIL sb_fill: got thr %0d arg %0d data %0h, expected wr %0d thr %0d arg %0d data %0h",
                         t, arg, d, e.is_wr, e.thr, e.arg, e.data);
            end
        end
    endtask

    task automatic sb_write(input int t);
        ev_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_wr_done: thread %0d, expected nothing", t);
        end else begin
            e = sb_q.pop_front();
            if (!e.is_wr || e.thr != 3'(t)) begin
                n_err++;
                $display("FAIL sb_wr_done: got thr %0d, expected wr %0d thr %0d", t, e.is_wr, e.thr);
            end
        end
    endtask

    task automatic push_rd(input logic [2:0] t, input logic a, input logic [63:0] d);
        ev_t e;
        e.is_wr = 1'b0; e.thr = t; e.arg = a; e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic push_wr(input logic [2:0] t);
        ev_t e;
        e.is_wr = 1'b1; e.thr = t; e.arg = 1'b0; e.data = 64'h0;
        sb_q.push_back(e);
    endtask

    task automatic cleanup();
        i_consume = 8'hFF;
        i_err_clr = 8'hFF;
        step();
        i_consume = 8'h00;
        i_err_clr = 8'h00;
    endtask

    // Monitor: every rising slot valid or write pulse retires one expected event
    initial begin
        logic [7:0] prs;
        logic [7:0] prt;
        prs = '0;
        prt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prs = '0;
                prt = '0;
            end else begin
                for (int t = 0; t < 8; t++) begin
                    if (o_rs_vld[t] && !prs[t]) sb_read(t, ARG_RS, o_rs_data[64*t +: 64]);
                    if (o_rt_vld[t] && !prt[t]) sb_read(t, ARG_RT, o_rt_data[64*t +: 64]);
                    if (o_wr_done[t]) sb_write(t);
                end
                prs = o_rs_vld;
                prt = o_rt_vld;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        i_rss_wr = 1'b0; i_rss = '0; i_rsd_wr = 1'b0; i_rsd = '0;
        i_consume = '0; i_err_clr = '0;

        vecs[0] = '{3'd3, ARG_RS, 1'b1, 2'b00, 64'hDEAD_BEEF_0123_4567, 8'h08, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{3'd5, ARG_RS, 1'b0, 2'b00, 64'h0,                  8'h00, 8'h00, 8'h20, 8'h00};
        vecs[2] = '{3'd2, ARG_RT, 1'b1, 2'b00, 64'hA5A5_5A5A_F00D_CAFE, 8'h00, 8'h04, 8'h00, 8'h00};
        vecs[3] = '{3'd7, ARG_RS, 1'b0, 2'b10, 64'h0,                  8'h00, 8'h00, 8'h80, 8'h80};
        vecs[4] = '{3'd0, ARG_RS, 1'b1, 2'b01, 64'h0BAD_0BAD_0BAD_0BAD, 8'h01, 8'h00, 8'h00, 8'h01};
        vecs[5] = '{3'd6, ARG_RT, 1'b1, 2'b00, 64'h1234_5678_9ABC_DEF0, 8'h00, 8'h40, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_rs_vld",   o_rs_vld,   8'h00);
        chk("rst_rt_vld",   o_rt_vld,   8'h00);
        chk("rst_wr_done",  o_wr_done,  8'h00);
        chk("rst_err_vld",  o_err_vld,  8'h00);
        chk("rst_misroute", o_misroute, 1'b0);
        chk("rst_rss_rdy",  o_rss_rdy,  1'b1);
        chk("rst_rsd_rdy",  o_rsd_rdy,  1'b1);

        // Single-transaction vectors from an empty, idle collector
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            if (v.rnw) push_rd(v.thr, v.arg, v.data);
            else       push_wr(v.thr);
            i_rss_wr = 1'b1;
            i_rss    = rss_pack(CLNT_VPU0, v.thr, v.arg, v.rnw, v.err);
            i_rsd_wr = v.rnw;
            i_rsd    = v.data;
            step();
            i_rss_wr = 1'b0;
            i_rsd_wr = 1'b0;
            chk($sformatf("v%0d_rsd_rdy", i), o_rsd_rdy, 1'b1);
            step();
            chk($sformatf("v%0d_rs_vld", i),   o_rs_vld,   v.e_rs);
            chk($sformatf("v%0d_rt_vld", i),   o_rt_vld,   v.e_rt);
            chk($sformatf("v%0d_wr_done", i),  o_wr_done,  v.e_wd);
            chk($sformatf("v%0d_err_vld", i),  o_err_vld,  v.e_err);
            chk($sformatf("v%0d_misroute", i), o_misroute, 1'b0);
            step();
            chk($sformatf("v%0d_wr_done_end", i), o_wr_done, 8'h00);
            cleanup();
            chk($sformatf("v%0d_vld_cleared", i), {o_rs_vld, o_rt_vld}, 16'h0000);
            chk($sformatf("v%0d_err_cleared", i), o_err_vld, 8'h00);
        end

        // Data lags the read status by four cycles; a write queues behind it
        push_rd(3'd1, ARG_RS, 64'h1111_2222_3333_4444);
        push_wr(3'd4);
        i_rss_wr = 1'b1;
        i_rss    = rss_pack(CLNT_VPU0, 3'd1, ARG_RS, 1'b1, 2'b00);
        step();
        i_rss    = rss_pack(CLNT_VPU0, 3'd4, ARG_RS, 1'b0, 2'b00);
        step();
        i_rss_wr = 1'b0;
        chk("lag_rss_rdy_full", o_rss_rdy, 1'b0);
        chk("lag_state_waitd",  dut.state_q, 1'b1);
        step();
        step();
        chk("lag_rs_vld_wait",  o_rs_vld, 8'h00);
        chk("lag_state_hold",   dut.state_q, 1'b1);
        i_rsd_wr = 1'b1;
        i_rsd    = 64'h1111_2222_3333_4444;
        step();
        i_rsd_wr = 1'b0;
        chk("lag_rs_vld_accept", o_rs_vld, 8'h00);
        step();
        chk("lag_rs_vld_fill",  o_rs_vld, 8'h02);
        chk("lag_state_idle",   dut.state_q, 1'b0);
        chk("lag_rss_rdy_back", o_rss_rdy, 1'b1);
        step();
        chk("lag_wr_done", o_wr_done, 8'h10);
        step();
        cleanup();

        // Occupied slot: head-of-line stall until the consumer frees it
        push_rd(3'd0, ARG_RS, 64'hAAAA_AAAA_AAAA_AAAA);
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU0, 3'd0, ARG_RS, 1'b1, 2'b00);
        i_rsd_wr = 1'b1; i_rsd = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        i_rss = rss_pack(CLNT_VPU0, 3'd0, ARG_RS, 1'b1, 2'b00);
        i_rsd = 64'h1;
        step();
        chk("occ_first_fill", o_rs_vld, 8'h01);
        i_rss = rss_pack(CLNT_VPU0, 3'd2, ARG_RT, 1'b1, 2'b00);
        i_rsd = 64'h2;
        step();
        i_rss_wr = 1'b0; i_rsd_wr = 1'b0;
        chk("occ_rss_rdy", o_rss_rdy, 1'b0);
        chk("occ_rsd_rdy", o_rsd_rdy, 1'b0);
        step();
        step();
        chk("occ_rs_data_kept", o_rs_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("occ_rs_vld_kept",  o_rs_vld, 8'h01);
        push_rd(3'd2, ARG_RT, 64'h2);
        i_consume = 8'h01;
        step();
        i_consume = 8'h00;
        chk("occ_refill_vld",  o_rs_vld, 8'h01);
        chk("occ_refill_data", o_rs_data[63:0], 64'h1);
        chk("occ_rss_rdy_back", o_rss_rdy, 1'b1);
        step();
        chk("occ_next_fill", o_rt_vld, 8'h04);
        cleanup();

        // Error sticky bit: set wins over a coincident clear
        push_wr(3'd7);
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU0, 3'd7, ARG_RS, 1'b0, 2'b10);
        step();
        i_rss_wr = 1'b0;
        step();
        chk("err_set", o_err_vld, 8'h80);
        push_wr(3'd7);
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU0, 3'd7, ARG_RS, 1'b0, 2'b11);
        step();
        i_rss_wr = 1'b0;
        i_err_clr = 8'h80;
        step();
        chk("err_set_wins", o_err_vld, 8'h80);
        step();
        i_err_clr = 8'h00;
        chk("err_cleared", o_err_vld, 8'h00);

        // Misrouted read consumes one data word and touches no slot
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU1, 3'd4, ARG_RS, 1'b1, 2'b00);
        i_rsd_wr = 1'b1; i_rsd = 64'h9999_9999_9999_9999;
        step();
        i_rss_wr = 1'b0; i_rsd_wr = 1'b0;
        step();
        chk("mis_flag",   o_misroute, 1'b1);
        chk("mis_no_vld", {o_rs_vld, o_rt_vld}, 16'h0000);
        push_rd(3'd4, ARG_RS, 64'h4444_0000_4444_0000);
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU0, 3'd4, ARG_RS, 1'b1, 2'b00);
        i_rsd_wr = 1'b1; i_rsd = 64'h4444_0000_4444_0000;
        step();
        i_rss_wr = 1'b0; i_rsd_wr = 1'b0;
        step();
        chk("mis_next_vld",  o_rs_vld, 8'h10);
        chk("mis_next_data", o_rs_data[319:256], 64'h4444_0000_4444_0000);
        chk("mis_sticky",    o_misroute, 1'b1);
        cleanup();

        // Reset while stalled discards queued responses
        push_rd(3'd0, ARG_RS, 64'h5);
        i_rss_wr = 1'b1; i_rss = rss_pack(CLNT_VPU0, 3'd0, ARG_RS, 1'b1, 2'b00);
        i_rsd_wr = 1'b1; i_rsd = 64'h5;
        step();
        i_rss = rss_pack(CLNT_VPU0, 3'd0, ARG_RS, 1'b1, 2'b00);
        i_rsd = 64'h6;
        step();
        i_rss = rss_pack(CLNT_VPU0, 3'd1, ARG_RT, 1'b1, 2'b00);
        i_rsd = 64'h7;
        step();
        i_rss_wr = 1'b0; i_rsd_wr = 1'b0;
        step();
        chk("rst2_stalled", o_rss_rdy, 1'b0);
        rst = 1'b1;
        sb_q.delete();
        #2;
        chk("rst2_async_vld", o_rs_vld, 8'h00);
        step();
        rst = 1'b0;
        step();
        chk("rst2_rs_vld",   o_rs_vld,   8'h00);
        chk("rst2_rt_vld",   o_rt_vld,   8'h00);
        chk("rst2_rss_rdy",  o_rss_rdy,  1'b1);
        chk("rst2_rsd_rdy",  o_rsd_rdy,  1'b1);
        chk("rst2_misroute", o_misroute, 1'b0);
        step();
        step();
        chk("rst2_discarded", {o_rs_vld, o_rt_vld}, 16'h0000);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
